// File: rtl/alto_shifter_if.sv
// Bundle of datapath inputs and register/shifter outputs for the Alto shifter.
// The slave side is the shifter itself; the master side drives controls and data.
interface alto_shifter_if;
   logic [15:0] alu_i;
   logic        alu_carry_i;
   logic [15:0] bus_i;
   logic        load_l_i;
   logic        load_t_i;
   logic        t_sel_i;
   logic [1:0]  sh_f_i;
   logic        magic_i;
   logic        dns_i;
   logic [1:0]  cc_i;
   logic [2:0]  skf_i;
   logic [15:0] l_o;
   logic [15:0] t_o;
   logic [15:0] sh_o;
   logic        sh_zero_o;
   logic        sh_neg_o;
   logic        aluc0_o;
   logic        carry_o;
   logic        skip_o;

   modport slave (
      input  alu_i, alu_carry_i, bus_i, load_l_i, load_t_i, t_sel_i,
             sh_f_i, magic_i, dns_i, cc_i, skf_i,
      output l_o, t_o, sh_o, sh_zero_o, sh_neg_o, aluc0_o, carry_o, skip_o
   );

   modport master (
      output alu_i, alu_carry_i, bus_i, load_l_i, load_t_i, t_sel_i,
             sh_f_i, magic_i, dns_i, cc_i, skf_i,
      input  l_o, t_o, sh_o, sh_zero_o, sh_neg_o, aluc0_o, carry_o, skip_o
   );
endinterface

// File: rtl/alto_shifter.sv
// Alto L/T registers with combinational shifter, Nova carry and skip logic.
// Bit 15 is the MSB (Alto bit 0); the shifter acts on L/T as already registered.
module alto_shifter (
   input  logic           clk_i,
   input  logic           rst_i,
   alto_shifter_if.slave  sif
);
   localparam logic [1:0] SH_NONE = 2'd0;
   localparam logic [1:0] SH_LSH1 = 2'd1;
   localparam logic [1:0] SH_RSH1 = 2'd2;
   localparam logic [1:0] SH_LCY8 = 2'd3;

   logic [15:0] l_reg;
   logic [15:0] t_reg;
   logic        aluc0_reg;
   logic        carry_reg;
   logic        skip_reg;

   logic        cin;
   logic        ncarry;
   logic [15:0] sh_next;
   logic        sh_zero;
   logic        skip_next;

   always_comb begin
      cin = carry_reg;
      case (sif.cc_i)
         2'd0: cin = carry_reg;
         2'd1: cin = 1'b0;
         2'd2: cin = 1'b1;
         2'd3: cin = ~carry_reg;
         default: cin = carry_reg;
      endcase
   end

   // magic outranks dns for the fill bit, but ncarry still follows dns alone
   always_comb begin
      sh_next = l_reg;
      ncarry  = cin;
      case (sif.sh_f_i)
         SH_NONE: sh_next = l_reg;
         SH_LCY8: sh_next = {l_reg[7:0], l_reg[15:8]};
         SH_LSH1: begin
            if (sif.magic_i)    sh_next = {l_reg[14:0], t_reg[15]};
            else if (sif.dns_i) sh_next = {l_reg[14:0], cin};
            else                sh_next = {l_reg[14:0], 1'b0};
            if (sif.dns_i) ncarry = l_reg[15];
         end
         SH_RSH1: begin
            if (sif.magic_i)    sh_next = {t_reg[0], l_reg[15:1]};
            else if (sif.dns_i) sh_next = {cin, l_reg[15:1]};
            else                sh_next = {1'b0, l_reg[15:1]};
            if (sif.dns_i) ncarry = l_reg[0];
         end
         default: sh_next = l_reg;
      endcase
   end

   assign sh_zero = (sh_next == 16'h0000);

   always_comb begin
      skip_next = 1'b0;
      case (sif.skf_i)
         3'd0: skip_next = 1'b0;
         3'd1: skip_next = 1'b1;
         3'd2: skip_next = ~ncarry;
         3'd3: skip_next = ncarry;
         3'd4: skip_next = sh_zero;
         3'd5: skip_next = ~sh_zero;
         3'd6: skip_next = ~ncarry | sh_zero;
         3'd7: skip_next = ncarry & ~sh_zero;
         default: skip_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         l_reg     <= 16'h0000;
         t_reg     <= 16'h0000;
         aluc0_reg <= 1'b0;
         carry_reg <= 1'b0;
         skip_reg  <= 1'b0;
      end else begin
         if (sif.load_l_i) begin
            l_reg     <= sif.alu_i;
            aluc0_reg <= sif.alu_carry_i;
         end
         if (sif.load_t_i)
            t_reg <= sif.t_sel_i ? sif.alu_i : sif.bus_i;
         if (sif.dns_i) begin
            carry_reg <= ncarry;
            skip_reg  <= skip_next;
         end
      end
   end

   assign sif.l_o       = l_reg;
   assign sif.t_o       = t_reg;
   assign sif.sh_o      = sh_next;
   assign sif.sh_zero_o = sh_zero;
   assign sif.sh_neg_o  = sh_next[15];
   assign sif.aluc0_o   = aluc0_reg;
   assign sif.carry_o   = carry_reg;
   assign sif.skip_o    = skip_reg;
endmodule

// File: tb/tb_alto_shifter.sv
// Directed-vector bench for alto_shifter with hand-computed expectations.
module tb_alto_shifter;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   alto_shifter_if sif ();

   alto_shifter dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .sif   (sif.slave)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      sif.alu_i = 16'h0; sif.alu_carry_i = 1'b0; sif.bus_i = 16'h0;
      sif.load_l_i = 1'b0; sif.load_t_i = 1'b0; sif.t_sel_i = 1'b0;
      sif.sh_f_i = 2'd0; sif.magic_i = 1'b0; sif.dns_i = 1'b0;
      sif.cc_i = 2'd0; sif.skf_i = 3'd0;
   endtask

   initial begin
      idle();
      // reset overrides a same-cycle load and dns
      rst_i = 1'b1; sif.load_l_i = 1'b1; sif.alu_i = 16'hFFFF;
      sif.load_t_i = 1'b1; sif.bus_i = 16'hFFFF; sif.dns_i = 1'b1; sif.cc_i = 2'd2; sif.skf_i = 3'd1;
      tick();
      tick();
      rst_i = 1'b0; idle(); #1;
      check("rst_l", sif.l_o, 16'h0000);
      check("rst_t", sif.t_o, 16'h0000);
      check("rst_carry", {15'd0, sif.carry_o}, 16'd0);
      check("rst_skip", {15'd0, sif.skip_o}, 16'd0);
      check("rst_aluc0", {15'd0, sif.aluc0_o}, 16'd0);
      check("rst_sh", sif.sh_o, 16'h0000);
      check("rst_zero", {15'd0, sif.sh_zero_o}, 16'd1);

      // load L=8001 with ALU carry, then set Nova carry via cc=one
      sif.load_l_i = 1'b1; sif.alu_i = 16'h8001; sif.alu_carry_i = 1'b1;
      tick(); idle();
      check("load_l", sif.l_o, 16'h8001);
      check("aluc0", {15'd0, sif.aluc0_o}, 16'd1);
      sif.dns_i = 1'b1; sif.cc_i = 2'd2;
      tick(); idle(); #1;
      check("carry_set", {15'd0, sif.carry_o}, 16'd1);
      sif.sh_f_i = 2'd1; #1;
      check("lsh1", sif.sh_o, 16'h0002);
      check("lsh1_neg", {15'd0, sif.sh_neg_o}, 16'd0);
      sif.sh_f_i = 2'd3; #1;
      check("lcy8", sif.sh_o, 16'h0180);
      sif.sh_f_i = 2'd2; #1;
      check("rsh1", sif.sh_o, 16'h4000);

      // magic shift: L=0001, T=8000 from bus
      sif.sh_f_i = 2'd0;
      sif.load_l_i = 1'b1; sif.alu_i = 16'h0001;
      sif.load_t_i = 1'b1; sif.t_sel_i = 1'b0; sif.bus_i = 16'h8000;
      tick(); idle();
      check("load_t_bus", sif.t_o, 16'h8000);
      sif.sh_f_i = 2'd2; sif.magic_i = 1'b1; #1;
      check("magic_rsh_t8000", sif.sh_o, 16'h0000);
      check("magic_zero", {15'd0, sif.sh_zero_o}, 16'd1);
      sif.load_t_i = 1'b1; sif.t_sel_i = 1'b1; sif.alu_i = 16'h0001;
      tick();
      sif.load_t_i = 1'b0; #1;
      check("load_t_alu", sif.t_o, 16'h0001);
      check("magic_rsh_t0001", sif.sh_o, 16'h8000);
      check("magic_neg", {15'd0, sif.sh_neg_o}, 16'd1);
      // loading T while magic is active: fill still comes from old T
      sif.load_t_i = 1'b1; sif.t_sel_i = 1'b0; sif.bus_i = 16'h0000; #1;
      check("magic_old_t", sif.sh_o, 16'h8000);
      tick(); idle(); #1;
      check("t_after", sif.t_o, 16'h0000);

      // Nova rotate: L=8000 and carry cleared in the same edge
      sif.load_l_i = 1'b1; sif.alu_i = 16'h8000; sif.dns_i = 1'b1; sif.cc_i = 2'd1;
      tick(); idle(); #1;
      check("carry_clr", {15'd0, sif.carry_o}, 16'd0);
      sif.sh_f_i = 2'd1; sif.dns_i = 1'b1; sif.cc_i = 2'd0; sif.skf_i = 3'd2; #1;
      check("nova_lsh", sif.sh_o, 16'h0000);
      tick(); #1;
      check("nova_carry", {15'd0, sif.carry_o}, 16'd1);
      check("nova_skip", {15'd0, sif.skip_o}, 16'd0);
      sif.cc_i = 2'd3; #1;
      check("nova_lsh_cc3", sif.sh_o, 16'h0000);
      tick(); idle(); #1;
      check("nova_carry_cc3", {15'd0, sif.carry_o}, 16'd1);

      // SZR skip
      sif.load_l_i = 1'b1; sif.alu_i = 16'h0000;
      tick(); idle();
      sif.dns_i = 1'b1; sif.skf_i = 3'd4;
      tick(); idle(); #1;
      check("szr_skip", {15'd0, sif.skip_o}, 16'd1);
      sif.load_l_i = 1'b1; sif.alu_i = 16'h0005;
      tick(); idle(); tick(); #1;
      check("skip_hold", {15'd0, sif.skip_o}, 16'd1);
      sif.dns_i = 1'b1; sif.skf_i = 3'd4;
      tick(); idle(); #1;
      check("szr_noskip", {15'd0, sif.skip_o}, 16'd0);

      // simultaneous load and dns: shift uses old L=1234, carry=1
      sif.load_l_i = 1'b1; sif.alu_i = 16'h1234;
      tick(); idle();
      sif.sh_f_i = 2'd2; sif.dns_i = 1'b1; sif.skf_i = 3'd5;
      sif.load_l_i = 1'b1; sif.alu_i = 16'hFFFF; #1;
      check("simul_sh", sif.sh_o, 16'h891A);
      tick(); idle(); #1;
      check("simul_skip", {15'd0, sif.skip_o}, 16'd1);
      check("simul_l", sif.l_o, 16'hFFFF);
      check("simul_carry", {15'd0, sif.carry_o}, 16'd0);

      // magic outranks dns for fill; carry follows L[15]; skf=7
      sif.sh_f_i = 2'd1; sif.magic_i = 1'b1; sif.dns_i = 1'b1; sif.cc_i = 2'd2; sif.skf_i = 3'd7; #1;
      check("magic_over_dns", sif.sh_o, 16'hFFFE);
      tick(); idle(); #1;
      check("skf7_skip", {15'd0, sif.skip_o}, 16'd1);
      check("skf7_carry", {15'd0, sif.carry_o}, 16'd1);
      sif.sh_f_i = 2'd2; sif.dns_i = 1'b1; sif.cc_i = 2'd3; sif.skf_i = 3'd6; #1;
      check("dns_rsh_cin0", sif.sh_o, 16'h7FFF);
      tick(); idle(); #1;
      check("skf6_skip", {15'd0, sif.skip_o}, 16'd0);

      // mid-sequence reset discards same-cycle loads
      rst_i = 1'b1; sif.load_l_i = 1'b1; sif.alu_i = 16'h5555;
      sif.load_t_i = 1'b1; sif.bus_i = 16'hAAAA;
      tick(); rst_i = 1'b0; idle(); #1;
      check("rst2_l", sif.l_o, 16'h0000);
      check("rst2_t", sif.t_o, 16'h0000);
      check("rst2_carry", {15'd0, sif.carry_o}, 16'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
